// File: rtl/star_pkg.sv
// Shared constants and types for the star network-interface transmitter.
// Header flits are an 8-bit marker+destination pattern, zero-extended to the flit width.
package star_pkg;

  localparam int unsigned STAR_DATAWID = 8;
  localparam int unsigned STAR_NODES   = 10;
  localparam int unsigned HDR_MARK_BIT = 7;

  typedef enum logic [1:0] {
    FlitPay = 2'd0,
    FlitLen = 2'd1,
    FlitHdr = 2'd2
  } flit_type_e;

  typedef enum logic [1:0] {
    StCollect = 2'd0,
    StHdr     = 2'd1,
    StLen     = 2'd2,
    StPay     = 2'd3
  } state_e;

endpackage

// File: rtl/star_ni_fifo.sv
// Payload buffer: DEPTH x DATAWID FIFO with async-reset pointers and a flush input.
// Read data is the head entry, valid whenever the FIFO is not empty.
module star_ni_fifo #(
  parameter int unsigned DATAWID = 8,
  parameter int unsigned DEPTH   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push,
  input  logic [DATAWID-1:0] wdata,
  input  logic               pop,
  output logic [DATAWID-1:0] rdata,
  output logic               empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned UW = $clog2(DEPTH + 1);

  logic [DATAWID-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [UW-1:0]      used_q, used_d;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    used_d   = used_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      used_d   = '0;
    end else begin
      if (push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      if (push && !pop)      used_d = used_q + UW'(1);
      else if (pop && !push) used_d = used_q - UW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      used_q   <= used_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign empty = (used_q == '0);

endmodule

// File: rtl/star_ni_tx.sv
// Network-interface transmitter: buffers a source packet, then emits header, length
// and payload flits towards a leaf router; packets for unknown routers are dropped.
module star_ni_tx
  import star_pkg::*;
#(
  parameter int unsigned DATAWID = STAR_DATAWID,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned NODES   = STAR_NODES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATAWID-1:0] in_data,
  input  logic               in_last,
  input  logic [3:0]         in_dest,
  output logic [DATAWID-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic [7:0]         drop_count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [3:0]         dest_q, dest_d;
  logic [DATAWID-1:0] out_data_q, out_data_d;
  logic [7:0]         drop_q, drop_d;

  logic               fifo_push, fifo_pop, fifo_flush, fifo_empty;
  logic [DATAWID-1:0] fifo_rdata;
  logic [3:0]         dest_eff;
  logic               dest_ok, closing;

  function automatic logic [DATAWID-1:0] hdr_flit(input logic [3:0] d);
    logic [DATAWID-1:0] f;
    f               = '0;
    f[HDR_MARK_BIT] = 1'b1;
    f[3:0]          = d;
    return f;
  endfunction

  // Destination comes from the first word; a one-word packet closes on that same word.
  assign dest_eff = (count_q == '0) ? in_dest : dest_q;
  assign dest_ok  = (dest_eff != 4'd0) && (32'(dest_eff) <= NODES);
  assign closing  = in_last || (count_q == CW'(DEPTH - 1));

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    dest_d     = dest_q;
    out_data_d = out_data_q;
    drop_d     = drop_q;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    unique case (state_q)
      StCollect: begin
        if (in_valid) begin
          fifo_push = 1'b1;
          count_d   = count_q + CW'(1);
          if (count_q == '0) dest_d = in_dest;
          if (closing) begin
            if (dest_ok) begin
              state_d    = StHdr;
              out_data_d = hdr_flit(dest_eff);
            end else begin
              fifo_flush = 1'b1;
              count_d    = '0;
              if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
            end
          end
        end
      end
      StHdr: begin
        if (out_ready) begin
          state_d    = StLen;
          out_data_d = DATAWID'(count_q - CW'(1));
        end
      end
      StLen: begin
        if (out_ready) begin
          state_d    = StPay;
          out_data_d = fifo_rdata;
          fifo_pop   = 1'b1;
        end
      end
      StPay: begin
        if (out_ready) begin
          if (!fifo_empty) begin
            out_data_d = fifo_rdata;
            fifo_pop   = 1'b1;
          end else begin
            state_d    = StCollect;
            count_d    = '0;
            out_data_d = '0;
          end
        end
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StCollect;
      count_q    <= '0;
      dest_q     <= '0;
      out_data_q <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      dest_q     <= dest_d;
      out_data_q <= out_data_d;
      drop_q     <= drop_d;
    end
  end

  star_ni_fifo #(
    .DATAWID(DATAWID),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .flush(fifo_flush),
    .push (fifo_push),
    .wdata(in_data),
    .pop  (fifo_pop),
    .rdata(fifo_rdata),
    .empty(fifo_empty)
  );

  assign in_ready   = (state_q == StCollect);
  assign out_valid  = (state_q != StCollect);
  assign busy       = out_valid || (count_q != '0);
  assign out_data   = out_data_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_star_ni_tx.sv
// Randomised bench for star_ni_tx: a packet-level model turns the input word stream
// into the expected flit sequence and drop count.
module tb_star_ni_tx;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned NODES = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_last;
  logic [DW-1:0] in_data;
  logic [3:0]    in_dest;
  logic [DW-1:0] out_data;
  logic          out_valid, out_ready, busy;
  logic [7:0]    drop_count;

  always #5 clk = ~clk;

  star_ni_tx #(
    .DATAWID(DW),
    .DEPTH  (DEPTH),
    .NODES  (NODES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_dest   (in_dest),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .drop_count(drop_count)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Input stream: one entry per source word
  logic [7:0] s_data[$];
  bit         s_last[$];
  logic [3:0] s_dest[$];

  logic [7:0] exp_q[$];
  logic [7:0] want[$];
  int         exp_drop = 0;

  logic [7:0] got[$];
  int         got_cyc[$];
  int         acc_cyc[$];
  logic [7:0] stall_data[$];
  logic       stall_valid[$];
  int         overlap, ready_low;

  task automatic clear_stream();
    s_data.delete();
    s_last.delete();
    s_dest.delete();
  endtask

  task automatic add_word(input logic [7:0] d, input bit last, input logic [3:0] dest);
    s_data.push_back(d);
    s_last.push_back(last);
    s_dest.push_back(dest);
  endtask

  // Non-first words carry junk destinations; only the first word's id may count.
  task automatic add_pkt(input logic [3:0] dest, input int n, input bit last);
    for (int i = 0; i < n; i++)
      add_word(8'($urandom), last && (i == n - 1), (i == 0) ? dest : 4'($urandom));
  endtask

  task automatic model();
    int         cnt;
    logic [3:0] d;
    logic [7:0] pk[$];
    cnt = 0;
    d   = '0;
    exp_q.delete();
    for (int i = 0; i < s_data.size(); i++) begin
      if (cnt == 0) d = s_dest[i];
      pk.push_back(s_data[i]);
      cnt++;
      if (s_last[i] || cnt == DEPTH) begin
        if (d >= 1 && d <= NODES) begin
          exp_q.push_back(8'h80 | {4'h0, d});
          exp_q.push_back(8'(cnt - 1));
          foreach (pk[j]) exp_q.push_back(pk[j]);
        end else if (exp_drop < 255) begin
          exp_drop++;
        end
        pk.delete();
        cnt = 0;
      end
    end
  endtask

  task automatic drive_in(input int idx, input bit gaps);
    if (idx < s_data.size()) begin
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = s_data[idx];
      in_last  = s_last[idx];
      in_dest  = s_dest[idx];
    end else begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  // Drives the stream and records flits. Called at posedge+1, returns at posedge+1.
  // ready_mode: 0 always ready, 1 random, 2 stall the length flit for 3 cycles.
  task automatic xfer(input int ready_mode, input bit gaps, input int exp_n, input int max_cyc,
                      output bit timeout);
    int idx;
    int stall;
    idx   = 0;
    stall = 0;
    got.delete();
    got_cyc.delete();
    acc_cyc.delete();
    stall_data.delete();
    stall_valid.delete();
    overlap   = 0;
    ready_low = 0;
    timeout   = 1'b1;
    drive_in(idx, gaps);
    for (int c = 0; c < max_cyc; c++) begin
      case (ready_mode)
        1: out_ready = ($urandom_range(0, 2) != 0);
        2: begin
          if (got.size() == 1 && stall < 3) begin
            out_ready = 1'b0;
            stall++;
            stall_data.push_back(out_data);
            stall_valid.push_back(out_valid);
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b1;
      endcase
      if (in_valid && in_ready) begin
        acc_cyc.push_back(cyc);
        idx++;
      end
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        got_cyc.push_back(cyc);
      end
      if (in_ready && out_valid) overlap++;
      if (!in_ready) ready_low++;
      @(posedge clk);
      #1;
      cyc++;
      drive_in(idx, gaps);
      if (idx >= s_data.size() && got.size() >= exp_n) begin
        timeout = 1'b0;
        break;
      end
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    in_dest   = '0;
    out_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid);
    end
    checks++;
    if (out_data !== 8'h00) begin
      errors++; $display("FAIL reset_out_data: got %02h want 00", out_data);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %0b want 0", busy);
    end
    checks++;
    if (drop_count !== 8'd0) begin
      errors++; $display("FAIL reset_drop_count: got %0d want 0", drop_count);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready);
    end
    exp_drop = 0;
    #11 rst = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_basic();
    bit to;
    clear_stream();
    add_word(8'h11, 1'b0, 4'd3);
    add_word(8'h22, 1'b0, 4'd3);
    add_word(8'h33, 1'b1, 4'd3);
    model();
    want.delete();
    want.push_back(8'h83); want.push_back(8'h02);
    want.push_back(8'h11); want.push_back(8'h22); want.push_back(8'h33);
    xfer(0, 1'b0, 5, 100, to);
    checks++;
    if (to || got.size() != 5) begin
      errors++; $display("FAIL basic_count: got %0d flits want 5 (timeout=%0b)", got.size(), to);
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (got[k] !== want[k]) begin
          errors++; $display("FAIL basic_flit%0d: got %02h want %02h", k, got[k], want[k]);
        end
      end
      checks++;
      if (got_cyc[0] != acc_cyc[2] + 1) begin
        errors++;
        $display("FAIL basic_hdr_latency: got cycle %0d want %0d", got_cyc[0], acc_cyc[2] + 1);
      end
      for (int k = 1; k < 5; k++) begin
        checks++;
        if (got_cyc[k] != got_cyc[0] + k) begin
          errors++;
          $display("FAIL basic_consecutive%0d: got cycle %0d want %0d", k, got_cyc[k],
                   got_cyc[0] + k);
        end
      end
    end
  endtask

  task automatic test_full_depth();
    bit to;
    clear_stream();
    add_pkt(4'd10, 8, 1'b0);
    model();
    want.delete();
    want.push_back(8'h8A);
    want.push_back(8'h07);
    foreach (s_data[i]) want.push_back(s_data[i]);
    xfer(0, 1'b0, 10, 100, to);
    checks++;
    if (to || got.size() != 10) begin
      errors++; $display("FAIL full_count: got %0d flits want 10 (timeout=%0b)", got.size(), to);
    end else begin
      for (int k = 0; k < 10; k++) begin
        checks++;
        if (got[k] !== want[k]) begin
          errors++; $display("FAIL full_flit%0d: got %02h want %02h", k, got[k], want[k]);
        end
      end
    end
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_return: got in_ready=%0b busy=%0b out_valid=%0b want 1 0 0",
               in_ready, busy, out_valid);
    end
  endtask

  task automatic test_drop();
    bit         to;
    logic [3:0] bad[2];
    bad[0] = 4'd0;
    bad[1] = 4'd11;
    for (int p = 0; p < 2; p++) begin
      clear_stream();
      add_pkt(bad[p], 2, 1'b1);
      model();
      xfer(1, 1'b0, 0, 50, to);
      checks++;
      if (to || got.size() != 0 || overlap != 0) begin
        errors++;
        $display("FAIL drop%0d_flits: got %0d flits want 0 (timeout=%0b)", p, got.size(), to);
      end
      checks++;
      if (drop_count !== 8'(exp_drop) || drop_count !== 8'(p + 1)) begin
        errors++; $display("FAIL drop%0d_count: got %0d want %0d", p, drop_count, p + 1);
      end
      checks++;
      if (ready_low != 0 || in_ready !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL drop%0d_ready: got low_cycles=%0d in_ready=%0b busy=%0b want 0 1 0",
                 p, ready_low, in_ready, busy);
      end
    end
  endtask

  task automatic test_stall_len();
    bit to;
    clear_stream();
    add_pkt(4'd5, 3, 1'b1);
    model();
    xfer(2, 1'b0, exp_q.size(), 100, to);
    checks++;
    if (stall_data.size() != 3) begin
      errors++; $display("FAIL stall_cycles: got %0d want 3", stall_data.size());
    end
    for (int k = 0; k < stall_data.size(); k++) begin
      checks++;
      if (stall_data[k] !== 8'h02 || stall_valid[k] !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold%0d: got data=%02h valid=%0b want 02 1", k, stall_data[k],
                 stall_valid[k]);
      end
    end
    checks++;
    if (to || got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL stall_count: got %0d flits want %0d", got.size(), exp_q.size());
    end else begin
      for (int k = 0; k < got.size(); k++) begin
        checks++;
        if (got[k] !== exp_q[k]) begin
          errors++; $display("FAIL stall_flit%0d: got %02h want %02h", k, got[k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    clear_stream();
    add_pkt(4'd1, 2, 1'b1);
    add_pkt(4'd9, 4, 1'b1);
    add_pkt(4'd4, 1, 1'b1);
    model();
    xfer(0, 1'b0, exp_q.size(), 200, to);
    checks++;
    if (overlap != 0) begin
      errors++; $display("FAIL b2b_in_ready_overlap: got %0d cycles want 0", overlap);
    end
    checks++;
    if (to || got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count: got %0d flits want %0d", got.size(), exp_q.size());
    end else begin
      for (int k = 0; k < got.size(); k++) begin
        checks++;
        if (got[k] !== exp_q[k]) begin
          errors++; $display("FAIL b2b_flit%0d: got %02h want %02h", k, got[k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    bit to;
    clear_stream();
    for (int p = 0; p < 12; p++)
      add_pkt(4'($urandom_range(0, 12)), $urandom_range(1, 10), $urandom_range(0, 3) != 0);
    s_last[s_last.size() - 1] = 1'b1;
    model();
    xfer(1, 1'b1, exp_q.size(), 4000, to);
    checks++;
    if (to || got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count: got %0d flits want %0d (timeout=%0b)", got.size(),
               exp_q.size(), to);
    end else begin
      for (int k = 0; k < got.size(); k++) begin
        checks++;
        if (got[k] !== exp_q[k]) begin
          errors++; $display("FAIL rand_flit%0d: got %02h want %02h", k, got[k], exp_q[k]);
        end
      end
    end
    checks++;
    if (drop_count !== 8'(exp_drop)) begin
      errors++; $display("FAIL rand_drop_count: got %0d want %0d", drop_count, exp_drop);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    clear_stream();
    add_pkt(4'd6, 4, 1'b1);
    xfer(0, 1'b0, 3, 100, to);
    checks++;
    if (to || got.size() != 3) begin
      errors++; $display("FAIL rmid_setup: got %0d flits want 3", got.size());
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00 || drop_count !== 8'd0) begin
      errors++;
      $display("FAIL rmid_async: got valid=%0b busy=%0b data=%02h drops=%0d want 0 0 00 0",
               out_valid, busy, out_data, drop_count);
    end
    exp_drop = 0;
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rmid_release: got valid=%0b in_ready=%0b want 0 1", out_valid, in_ready);
    end
    clear_stream();
    add_pkt(4'd7, 2, 1'b1);
    model();
    xfer(0, 1'b0, exp_q.size(), 100, to);
    checks++;
    if (to || got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rmid_count: got %0d flits want %0d", got.size(), exp_q.size());
    end else begin
      for (int k = 0; k < got.size(); k++) begin
        checks++;
        if (got[k] !== exp_q[k]) begin
          errors++; $display("FAIL rmid_flit%0d: got %02h want %02h", k, got[k], exp_q[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_depth();
    test_drop();
    test_stall_len();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
